fetch_unit: RTL and testbench

Instruction fetch controller that sequences the combinational `instruction_memory`. It owns the program counter and drives the memory address. Each fetched word is captured with its PC into a small queue and presented to decode over a valid/ready handshake. Decode or execute can redirect it for branches and jumps; it sits between `instruction_memory` and the decode stage.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit and its queue.
package fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Sequential fetch address; wraps silently at the top of the address space.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched {pc, instr} pairs; head outputs read as zero when empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_push,
   input  logic [XLEN-1:0]             i_push_pc,
   input  logic [XLEN-1:0]             i_push_instr,
   input  logic                        i_pop,
   input  logic                        i_flush,
   output logic [$clog2(QDEPTH):0]     o_count,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [XLEN-1:0]             o_head_pc,
   output logic [XLEN-1:0]             o_head_instr
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t       r_mem [QDEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_empty;
   logic               w_full;
   logic               w_do_pop;
   logic               w_do_push;
   fetch_entry_t       w_head;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(QDEPTH));
   // A flush discards both the pop and the push of the same cycle.
   assign w_do_pop  = i_pop && !w_empty && !i_flush;
   assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries data only; validity is tracked by r_count.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= '{pc: i_push_pc, instr: i_push_instr};
   end

   assign w_head       = r_mem[r_rd_ptr];
   assign o_head_pc    = w_empty ? '0 : w_head.pc;
   assign o_head_instr = w_empty ? '0 : w_head.instr;
   assign o_count      = r_count;
   assign o_full       = w_full;
   assign o_empty      = w_empty;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns the PC, sequences instruction_memory and
// feeds decode through a small queue, with redirect and misaligned-target fault handling.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;

   fetch_state_t       r_state;
   logic [XLEN-1:0]    r_pc;
   logic               r_fault;
   logic [XLEN-1:0]    r_fault_pc;

   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_space;
   logic               w_push;

   assign w_pop   = !w_empty && out_ready;
   // A full queue still has room when its head leaves this cycle.
   assign w_space = (w_count < CNT_W'(QDEPTH)) || (w_full && w_pop);
   assign w_push  = (r_state == RUN) && !redirect_valid && !halt && w_space;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_fault    <= 1'b0;
         r_fault_pc <= '0;
      end else if (redirect_valid) begin
         if (is_aligned(redirect_pc)) begin
            r_pc    <= redirect_pc;
            r_fault <= 1'b0;
            if (r_state != IDLE)
               r_state <= RUN;
         end else begin
            r_state    <= FAULT;
            r_fault    <= 1'b1;
            r_fault_pc <= redirect_pc;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (start)
                  r_state <= RUN;
            end
            RUN: begin
               if (halt)
                  r_state <= IDLE;
               else if (w_push)
                  r_pc <= next_pc(r_pc);
            end
            FAULT: begin
               r_state <= FAULT;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_push),
      .i_push_pc    (r_pc),
      .i_push_instr (imem_instr),
      .i_pop        (out_ready),
      .i_flush      (redirect_valid),
      .o_count      (w_count),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_head_pc    (out_pc),
      .o_head_instr (out_instr)
   );

   assign imem_addr = r_pc;
   assign out_valid = !w_empty;
   assign fault     = r_fault;
   assign fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected PCs, a negedge monitor checks pops.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, halt, out_ready, redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_instr, out_instr, out_pc, fault_pc;
   logic        out_valid, fault;

   logic        w2_start, w2_ready, w2_valid, w2_fault;
   logic [31:0] w2_addr, w2_instr_in, w2_instr, w2_pc, w2_fault_pc;

   int errors = 0;
   int checks = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   // Memory image: word at address a is {a[23:0], 8'h13} (addi-style pattern).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   assign imem_instr  = mem_word(imem_addr);
   assign w2_instr_in = mem_word(w2_addr);

   fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fault(fault), .fault_pc(fault_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .start(w2_start), .halt(1'b0),
      .imem_addr(w2_addr), .imem_instr(w2_instr_in),
      .out_valid(w2_valid), .out_ready(w2_ready),
      .out_instr(w2_instr), .out_pc(w2_pc),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .fault(w2_fault), .fault_pc(w2_fault_pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted head must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc %h with empty scoreboard (t=%0t)", out_pc, $time);
         end else begin
            logic [31:0] exp_pc;
            exp_pc = sb_q.pop_front();
            chk("pop_pc", out_pc, exp_pc);
            chk("pop_instr", out_instr, mem_word(exp_pc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      w2_start = 1'b0; w2_ready = 1'b0;
      #12;
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_fault", {31'b0, fault}, 32'h0);
      chk("rst_fault_pc", fault_pc, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_addr_wrap", w2_addr, 32'hFFFF_FFF8);

      // Streaming: first entry two edges after release, then one per cycle.
      rst_n = 1'b1; start = 1'b1; out_ready = 1'b1;
      sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
      tick();
      chk("run_lat_valid", {31'b0, out_valid}, 32'h0);
      tick(); chk("stream_valid0", {31'b0, out_valid}, 32'h1);
      tick(); chk("stream_valid1", {31'b0, out_valid}, 32'h1);
      tick(); chk("stream_valid2", {31'b0, out_valid}, 32'h1);
      start = 1'b0;
      tick();
      out_ready = 1'b0; halt = 1'b1;
      tick();
      halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect_valid = 1'b0;
      chk("idle_redir_valid", {31'b0, out_valid}, 32'h0);
      chk("idle_redir_addr", imem_addr, 32'h0);

      // Backpressure: queue fills at two entries, PC parks at 8.
      start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      chk("bp_addr_k", imem_addr, 32'h8);
      chk("bp_head_k", out_pc, 32'h0);
      tick();
      chk("bp_addr", imem_addr, 32'h8);
      chk("bp_head", out_pc, 32'h0);
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
      out_ready = 1'b1;
      tick(); tick(); tick();

      // Redirect with a full queue and ready high: old entries are dropped.
      chk("pre_redir_head", out_pc, 32'hC);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      chk("redir_flush_valid", {31'b0, out_valid}, 32'h0);
      chk("redir_addr", imem_addr, 32'h100);
      sb_q.push_back(32'h100); sb_q.push_back(32'h104);
      tick(); tick(); tick();

      // Misaligned redirect faults and freezes fetch.
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect_valid = 1'b0;
      chk("fault_set", {31'b0, fault}, 32'h1);
      chk("fault_pc", fault_pc, 32'h102);
      chk("fault_flush", {31'b0, out_valid}, 32'h0);
      chk("fault_pc_hold", imem_addr, 32'h10C);
      start = 1'b1; halt = 1'b1;
      tick();
      start = 1'b0; halt = 1'b0;
      chk("fault_sticky", {31'b0, fault}, 32'h1);
      chk("fault_no_push", {31'b0, out_valid}, 32'h0);
      chk("fault_addr", imem_addr, 32'h10C);
      redirect_valid = 1'b1; redirect_pc = 32'h200; out_ready = 1'b1;
      sb_q.push_back(32'h200);
      tick();
      redirect_valid = 1'b0;
      chk("fault_clear", {31'b0, fault}, 32'h0);
      chk("fault_pc_kept", fault_pc, 32'h102);
      chk("recover_addr", imem_addr, 32'h200);
      tick(); tick();

      // Halt with one entry queued: it drains, nothing new is fetched.
      out_ready = 1'b0; halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_addr", imem_addr, 32'h208);
      chk("halt_head", out_pc, 32'h204);
      chk("halt_valid", {31'b0, out_valid}, 32'h1);
      sb_q.push_back(32'h204);
      out_ready = 1'b1;
      tick();
      chk("drain_empty", {31'b0, out_valid}, 32'h0);
      chk("drain_addr", imem_addr, 32'h208);
      tick();
      chk("drain_empty2", {31'b0, out_valid}, 32'h0);

      // Asynchronous reset in the middle of a redirect cycle.
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_valid", {31'b0, out_valid}, 32'h0);
      chk("arst_pc", out_pc, 32'h0);
      chk("arst_instr", out_instr, 32'h0);
      chk("arst_fault", {31'b0, fault}, 32'h0);
      chk("arst_fault_pc", fault_pc, 32'h0);
      chk("arst_addr_wrap", w2_addr, 32'hFFFF_FFF8);
      redirect_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("sb_empty", sb_q.size(), 32'd0);

      // Wrap instance: PC rolls from 0xFFFFFFFC to 0.
      w2_start = 1'b1; w2_ready = 1'b1;
      tick();
      w2_start = 1'b0;
      tick();
      chk("wrap_pc0", w2_pc, 32'hFFFF_FFF8);
      chk("wrap_instr0", w2_instr, mem_word(32'hFFFF_FFF8));
      tick();
      chk("wrap_pc1", w2_pc, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc2", w2_pc, 32'h0000_0000);
      chk("wrap_valid2", {31'b0, w2_valid}, 32'h1);
      chk("wrap_no_fault", {31'b0, w2_fault}, 32'h0);
      w2_ready = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
